// File: rtl/edge_detect_pkg.sv
// Shared types and defaults for the multi-channel edge detector.
// Mode encoding is per channel, two bits each.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EM_OFF  = 2'b00,
    EM_RISE = 2'b01,
    EM_FALL = 2'b10,
    EM_BOTH = 2'b11
  } edge_mode_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_NUM_CH      = 8;
  localparam int DEFAULT_DB_CYCLES   = 4;

  function automatic logic edge_sel(
    input edge_mode_t m,
    input logic       r,
    input logic       f
  );
    logic v;
    v = 1'b0;
    unique case (m)
      EM_OFF:  v = 1'b0;
      EM_RISE: v = r;
      EM_FALL: v = f;
      EM_BOTH: v = r | f;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser with a configurable reset level.
// q is the output of the last stage.
module sync_chain
  import edge_detect_pkg::*;
#(
  parameter int STAGES      = DEFAULT_SYNC_STAGES,
  parameter int RESET_LEVEL = 0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  localparam logic RL = (RESET_LEVEL != 0);

  logic [STAGES-1:0] ff_q;
  logic [STAGES-1:0] ff_d;

  assign ff_d = {ff_q[STAGES-2:0], d};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ff_q <= {STAGES{RL}};
    end else begin
      ff_q <= ff_d;
    end
  end

  assign q = ff_q[STAGES-1];

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel synchronised edge detector with sticky pending flags and irq.
// Define EDGE_DEBOUNCE_EN to add a per-channel stability filter before detection.
module multi_edge_detect
  import edge_detect_pkg::*;
#(
  parameter int NUM_CH      = DEFAULT_NUM_CH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int RESET_LEVEL = 0,
  parameter int DB_CYCLES   = DEFAULT_DB_CYCLES
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_CH-1:0]   sig,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   ack,
  output logic [NUM_CH-1:0]   sig_edge,
  output logic [NUM_CH-1:0]   pending,
  output logic                irq
);

  localparam logic RL = (RESET_LEVEL != 0);

  if (NUM_CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_param
    $error("multi_edge_detect: illegal parameter value");
  end

  logic [NUM_CH-1:0] sync_y;
  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] h_q;
  logic [NUM_CH-1:0] edge_q;
  logic [NUM_CH-1:0] edge_d;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic              irq_q;
  logic              irq_d;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

    sync_chain #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (sig[ch]),
      .q     (sync_y[ch])
    );

`ifdef EDGE_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Level only moves after DB_CYCLES consecutive mismatching clocks
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync_y[ch] != lvl_q) begin
        if (cnt_q == CW'(DB_CYCLES - 1)) begin
          lvl_d = sync_y[ch];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt_q <= '0;
        lvl_q <= RL;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign s[ch] = lvl_q;
`else
    assign s[ch] = sync_y[ch];
`endif

    assign edge_d[ch] = edge_sel(
      edge_mode_t'(mode[2*ch +: 2]),
      s[ch] & ~h_q[ch],
      ~s[ch] & h_q[ch]
    );

  end : g_ch

  // A new edge wins over a same-cycle ack
  assign pend_d = edge_d | (pend_q & ~ack);
  assign irq_d  = |pend_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      h_q    <= {NUM_CH{RL}};
      edge_q <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      h_q    <= s;
      edge_q <= edge_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign sig_edge = edge_q;
  assign pending  = pend_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed table-driven bench for multi_edge_detect (default build).
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_multi_edge_detect;

  logic        clk;
  logic        n_rst;
  logic [7:0]  sig;
  logic [15:0] mode;
  logic [7:0]  ack;
  logic [7:0]  sig_edge;
  logic [7:0]  pending;
  logic        irq;

  int n_tests;
  int n_fail;

  multi_edge_detect dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .sig      (sig),
    .mode     (mode),
    .ack      (ack),
    .sig_edge (sig_edge),
    .pending  (pending),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  s;
    logic [15:0] m;
    logic [7:0]  a;
    logic [7:0]  e_edge;
    logic [7:0]  e_pend;
    logic        e_irq;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] e_edge,
                         input logic [7:0] e_pend, input logic e_irq);
    chk({name, ".edge"}, sig_edge, e_edge);
    chk({name, ".pend"}, pending, e_pend);
    chk({name, ".irq"}, {7'd0, irq}, {7'd0, e_irq});
  endtask

  task automatic step(input logic [7:0] s, input logic [15:0] m, input logic [7:0] a);
    sig  = s;
    mode = m;
    ack  = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_rst   = 1'b0;
    sig     = 8'h00;
    mode    = 16'h5555;
    ack     = 8'h00;

    tbl[0]  = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'h01, 16'h5555, 8'h00, 8'h01, 8'h01, 1'b0};
    tbl[3]  = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h01, 1'b1};
    tbl[4]  = '{8'h03, 16'h5559, 8'h00, 8'h00, 8'h01, 1'b1};
    tbl[5]  = '{8'h03, 16'h5559, 8'h01, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{8'h03, 16'h5559, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{8'h01, 16'h5559, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h01, 16'h5559, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h01, 16'h5559, 8'h00, 8'h02, 8'h02, 1'b0};
    tbl[10] = '{8'h03, 16'h5551, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[11] = '{8'h03, 16'h5551, 8'h02, 8'h00, 8'h00, 1'b1};
    tbl[12] = '{8'h03, 16'h5551, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[13] = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[15] = '{8'h01, 16'h5555, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[16] = '{8'h03, 16'h555D, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[17] = '{8'h03, 16'h555D, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[18] = '{8'h03, 16'h555D, 8'h00, 8'h02, 8'h02, 1'b0};
    tbl[19] = '{8'h03, 16'h555D, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[20] = '{8'h01, 16'h555D, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[21] = '{8'h01, 16'h555D, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[22] = '{8'h01, 16'h555D, 8'h00, 8'h02, 8'h02, 1'b1};
    tbl[23] = '{8'h01, 16'h555D, 8'h00, 8'h00, 8'h02, 1'b1};
    tbl[24] = '{8'h01, 16'h555D, 8'h02, 8'h00, 8'h00, 1'b1};
    tbl[25] = '{8'h01, 16'h555D, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk_all("reset", 8'h00, 8'h00, 1'b0);

    // Table: ch0 rise, ch1 fall / masked fall / both
    n_rst = 1'b1;
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].s, tbl[i].m, tbl[i].a);
      chk_all($sformatf("row%0d", i), tbl[i].e_edge, tbl[i].e_pend, tbl[i].e_irq);
    end

    // Ack collides with a new ch2 edge, then a lone ack
    step(8'h05, 16'hFFFF, 8'h00);
    step(8'h05, 16'hFFFF, 8'h00);
    step(8'h05, 16'hFFFF, 8'h00);
    chk_all("ch2_rise", 8'h04, 8'h04, 1'b0);
    step(8'h01, 16'hFFFF, 8'h00);
    step(8'h01, 16'hFFFF, 8'h00);
    step(8'h01, 16'hFFFF, 8'h04);
    chk_all("ch2_set_ack", 8'h04, 8'h04, 1'b1);
    step(8'h01, 16'hFFFF, 8'h00);
    chk_all("ch2_hold", 8'h00, 8'h04, 1'b1);
    step(8'h01, 16'hFFFF, 8'h04);
    chk_all("ch2_ack", 8'h00, 8'h00, 1'b1);
    step(8'h01, 16'hFFFF, 8'h00);
    chk_all("ch2_irq_off", 8'h00, 8'h00, 1'b0);

    // All channels high across reset
    step(8'hFF, 16'h5555, 8'h00);
    step(8'hFF, 16'h5555, 8'h00);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_pre", 8'hFE, 8'hFE, 1'b0);
    n_rst = 1'b0;
    #1;
    chk_all("ff_async_rst", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_in_rst", 8'h00, 8'h00, 1'b0);
    n_rst = 1'b1;
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_r0", 8'h00, 8'h00, 1'b0);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_r1", 8'h00, 8'h00, 1'b0);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_r2", 8'hFF, 8'hFF, 1'b0);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_r3", 8'h00, 8'hFF, 1'b1);
    step(8'hFF, 16'h5555, 8'h00);
    chk_all("ff_r4", 8'h00, 8'hFF, 1'b1);

    // Reset while a ch4 edge is in the sync chain
    step(8'h00, 16'h5555, 8'hFF);
    step(8'h00, 16'h5555, 8'h00);
    step(8'h00, 16'h5555, 8'h00);
    step(8'h00, 16'h5555, 8'h00);
    step(8'h00, 16'h5555, 8'h00);
    chk_all("mid_idle", 8'h00, 8'h00, 1'b0);
    step(8'h10, 16'h5555, 8'h00);
    n_rst = 1'b0;
    #1;
    chk_all("mid_rst", 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("mid_rst_hold", 8'h00, 8'h00, 1'b0);
    n_rst = 1'b1;
    step(8'h10, 16'h5555, 8'h00);
    chk_all("mid_r0", 8'h00, 8'h00, 1'b0);
    step(8'h10, 16'h5555, 8'h00);
    chk_all("mid_r1", 8'h00, 8'h00, 1'b0);
    step(8'h10, 16'h5555, 8'h00);
    chk_all("mid_r2", 8'h10, 8'h10, 1'b0);
    step(8'h10, 16'h5555, 8'h00);
    chk_all("mid_r3", 8'h00, 8'h10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
